// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IFILL = 2'd1,
        DFILL = 2'd2
    } hz_state_t;

    localparam logic [3:0] REG_ZERO = 4'h0;

    // Per-stage pipeline controls, one bit per stall/flush line.
    typedef struct packed {
        logic stall_PC;
        logic stall_F_D;
        logic stall_D_X;
        logic stall_X_M;
        logic flush_F_D;
        logic flush_D_X;
        logic flush_M_W;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up until all-ones, then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and stall sequencer: load-use, taken-branch flush and cache-miss fills.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D_X_MemRead,
    input  logic [REG_W-1:0] D_X_reg_dest,
    input  logic [REG_W-1:0] F_D_reg_source1,
    input  logic [REG_W-1:0] F_D_reg_source2,
    input  logic             F_D_uses_src1,
    input  logic             F_D_uses_src2,
    input  logic             branch_taken,
    input  logic             imiss,
    input  logic             dmiss,
    input  logic             fill_ack,
    output logic             fill_req,
    output logic             fill_is_data,
    output logic             stall_PC,
    output logic             stall_F_D,
    output logic             stall_D_X,
    output logic             stall_X_M,
    output logic             flush_F_D,
    output logic             flush_D_X,
    output logic             flush_M_W,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t   state_q, state_d;
    logic        branch_pend_q, branch_pend_d;
    stage_ctrl_t ctrl;
    logic        load_use;
    logic        flush_inc;

    // Load in EX feeding a source that ID actually reads; R0 never creates a hazard.
    always_comb begin
        load_use = D_X_MemRead && (D_X_reg_dest != REG_W'(REG_ZERO)) &&
                   ((F_D_uses_src1 && (D_X_reg_dest == F_D_reg_source1)) ||
                    (F_D_uses_src2 && (D_X_reg_dest == F_D_reg_source2)));
    end

    // Decode stage controls, fill handshake and next state from state and inputs.
    always_comb begin
        ctrl          = '0;
        fill_req      = 1'b0;
        fill_is_data  = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;
        branch_pend_d = branch_pend_q;
        case (state_q)
            RUN: begin
                if (dmiss) begin
                    ctrl.stall_PC  = 1'b1;
                    ctrl.stall_F_D = 1'b1;
                    ctrl.stall_D_X = 1'b1;
                    ctrl.stall_X_M = 1'b1;
                    ctrl.flush_M_W = 1'b1;
                    fill_req       = 1'b1;
                    fill_is_data   = 1'b1;
                    state_d        = DFILL;
                end else if (imiss) begin
                    ctrl.stall_PC  = 1'b1;
                    ctrl.flush_F_D = 1'b1;
                    fill_req       = 1'b1;
                    state_d        = IFILL;
                end else if (branch_pend_q) begin
                    // Discard the wrong-path fetch left over from the I-fill.
                    ctrl.flush_F_D = 1'b1;
                    branch_pend_d  = 1'b0;
                    flush_inc      = 1'b1;
                end else if (load_use) begin
                    // branch_taken is ignored here; ID re-resolves next cycle.
                    ctrl.stall_PC  = 1'b1;
                    ctrl.stall_F_D = 1'b1;
                    ctrl.flush_D_X = 1'b1;
                end else if (branch_taken) begin
                    ctrl.flush_F_D = 1'b1;
                    flush_inc      = 1'b1;
                end
            end
            IFILL: begin
                // Back end keeps draining; dmiss is re-sampled once back in RUN.
                ctrl.stall_PC  = 1'b1;
                ctrl.flush_F_D = 1'b1;
                fill_req       = 1'b1;
                if (branch_taken) begin
                    branch_pend_d = 1'b1;
                end
                if (fill_ack) begin
                    state_d = RUN;
                end
            end
            DFILL: begin
                ctrl.stall_PC  = 1'b1;
                ctrl.stall_F_D = 1'b1;
                ctrl.stall_D_X = 1'b1;
                ctrl.stall_X_M = 1'b1;
                ctrl.flush_M_W = 1'b1;
                fill_req       = 1'b1;
                fill_is_data   = 1'b1;
                if (fill_ack) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Sequencer state and pending-branch flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    // Drive the individual stage-control outputs from the decoded struct.
    always_comb begin
        stall_PC  = ctrl.stall_PC;
        stall_F_D = ctrl.stall_F_D;
        stall_D_X = ctrl.stall_D_X;
        stall_X_M = ctrl.stall_X_M;
        flush_F_D = ctrl.flush_F_D;
        flush_D_X = ctrl.flush_D_X;
        flush_M_W = ctrl.flush_M_W;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (ctrl.stall_PC),
        .clr  (cnt_clear),
        .count(stall_cycles)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush_inc),
        .clr  (cnt_clear),
        .count(flush_count)
    );

endmodule
